// File: rtl/port_arbiter.sv
// Two-port (instruction A, data B) arbiter onto one physical-memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both ports request in IDLE.
module port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_a,
  input  logic [15:0] address_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [1:0]  wmask_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata,
  output logic [1:0]  fsm_state
);

  // Handshake: a port holds its request until the cycle its resp_x is high;
  // pmem strobes hold until pmem_resp, and a transaction completes in that cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] lat_address;
  logic [15:0] lat_wdata;
  logic [1:0]  lat_wmask;
  logic        b_pending;
  logic        grant_b;

  assign b_pending = read_b | write_b;

`ifdef ARB_ROUND_ROBIN_EN
  // last_b = 1 when B received the most recent grant; 0 after reset so B wins first.
  logic last_b;

  assign grant_b = b_pending && (!read_a || !last_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_b) begin
        last_b <= 1'b1;
      end else if (read_a) begin
        last_b <= 1'b0;
      end
    end
  end
`else
  assign grant_b = b_pending;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pmem_read   <= 1'b0;
      pmem_write  <= 1'b0;
      lat_address <= 16'h0000;
      lat_wdata   <= 16'h0000;
      lat_wmask   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_b) begin
            state       <= SERVE_B;
            lat_address <= address_b;
            lat_wdata   <= wdata_b;
            lat_wmask   <= wmask_b;
            // A simultaneous read and write request is handled as a write.
            pmem_write  <= write_b;
            pmem_read   <= ~write_b;
          end else if (read_a) begin
            state       <= SERVE_A;
            lat_address <= address_a;
            lat_wmask   <= 2'b11;
            pmem_read   <= 1'b1;
            pmem_write  <= 1'b0;
          end
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_address = lat_address;
  assign pmem_wdata   = lat_wdata;
  assign pmem_wmask   = lat_wmask;

  assign resp_a  = pmem_resp && (state == SERVE_A);
  assign resp_b  = pmem_resp && (state == SERVE_B);
  assign rdata_a = pmem_rdata;
  assign rdata_b = pmem_rdata;

  assign fsm_state = state;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed testbench for port_arbiter; honours ARB_ROUND_ROBIN_EN for the conflict scenario.
module tb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        read_a;
  logic [15:0] address_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;
  logic [1:0]  fsm_state;

  int n_checks;
  int n_fail;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_A    = 2'd1;
  localparam logic [1:0] ST_B    = 2'd2;

  port_arbiter dut (
    .clk(clk), .reset(reset),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
    n_checks++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {pmem_read, pmem_write}); end
    n_checks++; if ({resp_a, resp_b} !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b expected 00", {resp_a, resp_b}); end
    n_checks++; if ({pmem_address, pmem_wdata, pmem_wmask} !== 34'h0) begin n_fail++; $display("FAIL reset_latches: got %h/%h/%b expected 0", pmem_address, pmem_wdata, pmem_wmask); end
    reset = 1'b0;
  endtask

  task automatic test_read_a();
    int highs;
    highs = 0;
    read_a = 1'b1; address_a = 16'h0040;
    step();
    n_checks++; if (fsm_state !== ST_A) begin n_fail++; $display("FAIL read_a_state: got %0d expected %0d", fsm_state, ST_A); end
    n_checks++; if (pmem_address !== 16'h0040 || pmem_wmask !== 2'b11 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL read_a_pmem: got %h/%b/w%b expected 0040/11/w0", pmem_address, pmem_wmask, pmem_write); end
    n_checks++; if (resp_a !== 1'b0) begin n_fail++; $display("FAIL read_a_early_resp: got %b expected 0", resp_a); end
    if (pmem_read) highs++;
    step();
    if (pmem_read) highs++;
    step();
    if (pmem_read) highs++;
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    #1;
    n_checks++; if (resp_a !== 1'b1 || rdata_a !== 16'h1234) begin n_fail++; $display("FAIL read_a_resp: got %b/%h expected 1/1234", resp_a, rdata_a); end
    n_checks++; if (resp_b !== 1'b0) begin n_fail++; $display("FAIL read_a_resp_b: got %b expected 0", resp_b); end
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
    if (pmem_read) highs++;
    n_checks++; if (highs !== 3) begin n_fail++; $display("FAIL read_a_strobe_cycles: got %0d expected 3", highs); end
    n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL read_a_return_idle: got %0d expected 0", fsm_state); end
  endtask

  task automatic test_write_b();
    write_b = 1'b1; address_b = 16'h0102; wdata_b = 16'hBEEF; wmask_b = 2'b01;
    step();
    n_checks++; if ({pmem_write, pmem_read} !== 2'b10) begin n_fail++; $display("FAIL write_b_strobes: got %b expected 10", {pmem_write, pmem_read}); end
    n_checks++; if (pmem_address !== 16'h0102 || pmem_wdata !== 16'hBEEF || pmem_wmask !== 2'b01) begin n_fail++; $display("FAIL write_b_fields: got %h/%h/%b expected 0102/beef/01", pmem_address, pmem_wdata, pmem_wmask); end
    n_checks++; if (resp_b !== 1'b0) begin n_fail++; $display("FAIL write_b_early_resp: got %b expected 0", resp_b); end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if ({resp_a, resp_b} !== 2'b01) begin n_fail++; $display("FAIL write_b_resp: got %b expected 01", {resp_a, resp_b}); end
    step();
    pmem_resp = 1'b0; write_b = 1'b0; wdata_b = 16'h0000; address_b = 16'h0000;
    n_checks++; if (fsm_state !== ST_IDLE || pmem_write !== 1'b0) begin n_fail++; $display("FAIL write_b_idle: got st%0d w%b expected st0 w0", fsm_state, pmem_write); end
    n_checks++; if (pmem_address !== 16'h0102 || pmem_wdata !== 16'hBEEF || pmem_wmask !== 2'b01) begin n_fail++; $display("FAIL idle_hold: got %h/%h/%b expected 0102/beef/01", pmem_address, pmem_wdata, pmem_wmask); end
  endtask

  task automatic test_conflict();
    int rounds;
    logic [1:0]  exp_state;
    logic [15:0] exp_addr;
    logic [1:0]  exp_resp;
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rounds = 4;
`else
    rounds = 2;
`endif
    read_a = 1'b1; address_a = 16'h00A0; read_b = 1'b1; address_b = 16'h00B0;
    for (int i = 0; i < rounds; i++) begin
      exp_state = (i % 2 == 0) ? ST_B : ST_A;
      exp_addr  = (i % 2 == 0) ? 16'h00B0 : 16'h00A0;
      exp_resp  = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      n_checks++; if (fsm_state !== exp_state || pmem_address !== exp_addr) begin n_fail++; $display("FAIL conflict_grant%0d: got st%0d/%h expected st%0d/%h", i, fsm_state, pmem_address, exp_state, exp_addr); end
      pmem_resp = 1'b1;
      #1;
      n_checks++; if ({resp_a, resp_b} !== exp_resp) begin n_fail++; $display("FAIL conflict_resp%0d: got %b expected %b", i, {resp_a, resp_b}, exp_resp); end
      step();
      pmem_resp = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      if (i == 0) read_b = 1'b0;
`endif
      n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL conflict_idle%0d: got %0d expected 0", i, fsm_state); end
    end
    read_a = 1'b0; read_b = 1'b0;
  endtask

  task automatic test_address_hold();
    read_a = 1'b1; address_a = 16'h0010;
    step();
    address_a = 16'h0020;
    n_checks++; if (pmem_address !== 16'h0010) begin n_fail++; $display("FAIL hold_addr_c1: got %h expected 0010", pmem_address); end
    step();
    n_checks++; if (pmem_address !== 16'h0010 || fsm_state !== ST_A) begin n_fail++; $display("FAIL hold_addr_c2: got %h/st%0d expected 0010/st1", pmem_address, fsm_state); end
    pmem_resp = 1'b1; pmem_rdata = 16'h0F0F;
    #1;
    n_checks++; if (resp_a !== 1'b1 || pmem_address !== 16'h0010) begin n_fail++; $display("FAIL hold_addr_resp: got %b/%h expected 1/0010", resp_a, pmem_address); end
    step();
    pmem_resp = 1'b0; read_a = 1'b0;
  endtask

  task automatic test_idle_resp();
    pmem_resp = 1'b1; pmem_rdata = 16'hAAAA;
    #1;
    n_checks++; if ({resp_a, resp_b} !== 2'b00) begin n_fail++; $display("FAIL idle_resp: got %b expected 00", {resp_a, resp_b}); end
    n_checks++; if (rdata_a !== 16'hAAAA || rdata_b !== 16'hAAAA) begin n_fail++; $display("FAIL rdata_passthru: got %h/%h expected aaaa/aaaa", rdata_a, rdata_b); end
    step();
    n_checks++; if (fsm_state !== ST_IDLE || {pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL idle_resp_state: got st%0d %b expected st0 00", fsm_state, {pmem_read, pmem_write}); end
    pmem_resp = 1'b0;
  endtask

  task automatic test_rw_zero_mask();
    read_b = 1'b1; write_b = 1'b1; wmask_b = 2'b00; address_b = 16'h0200; wdata_b = 16'h5A5A;
    step();
    n_checks++; if ({pmem_write, pmem_read} !== 2'b10 || pmem_wmask !== 2'b00 || pmem_wdata !== 16'h5A5A) begin n_fail++; $display("FAIL rw_as_write: got %b/%b/%h expected 10/00/5a5a", {pmem_write, pmem_read}, pmem_wmask, pmem_wdata); end
    pmem_resp = 1'b1;
    #1;
    n_checks++; if (resp_b !== 1'b1) begin n_fail++; $display("FAIL zero_mask_resp: got %b expected 1", resp_b); end
    step();
    pmem_resp = 1'b0; read_b = 1'b0; write_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    write_b = 1'b1; wmask_b = 2'b11; address_b = 16'h0300; wdata_b = 16'h1111;
    step();
    step();
    n_checks++; if (pmem_write !== 1'b1 || fsm_state !== ST_B) begin n_fail++; $display("FAIL mid_wait: got w%b st%0d expected w1 st2", pmem_write, fsm_state); end
    reset = 1'b1;
    #1;
    n_checks++; if (pmem_write !== 1'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_reset_async: got w%b st%0d expected w0 st0", pmem_write, fsm_state); end
    step();
    reset = 1'b0; write_b = 1'b0; pmem_resp = 1'b1;
    #1;
    n_checks++; if ({resp_a, resp_b} !== 2'b00) begin n_fail++; $display("FAIL mid_late_resp: got %b expected 00", {resp_a, resp_b}); end
    step();
    n_checks++; if (fsm_state !== ST_IDLE || pmem_write !== 1'b0) begin n_fail++; $display("FAIL mid_final_idle: got st%0d w%b expected st0 w0", fsm_state, pmem_write); end
    pmem_resp = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    read_a = 1'b0; address_a = 16'h0;
    read_b = 1'b0; write_b = 1'b0; wmask_b = 2'b00; address_b = 16'h0; wdata_b = 16'h0;
    pmem_resp = 1'b0; pmem_rdata = 16'h0;
    test_reset();
    test_read_a();
    test_write_b();
    test_conflict();
    test_address_hold();
    test_idle_resp();
    test_rw_zero_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
- REQ-001 Single clock; reset is asynchronous and active-high.
- REQ-002 clk  in  1  rising-edge clock for all state.
- REQ-003 reset  in  1  async active-high reset.
- REQ-004 read_a  in  1  instruction-port read request, held until resp_a.
- REQ-005 address_a  in  16  instruction-port byte address.
- REQ-006 resp_a  out  1  instruction-port transaction complete.
- REQ-007 rdata_a  out  16  instruction-port read data.
- REQ-008 read_b  in  1  data-port read request, held until resp_b.
- REQ-009 write_b  in  1  data-port write request, held until resp_b.
- REQ-010 wmask_b  in  2  data-port byte enables, [1]=high byte.
- REQ-011 address_b  in  16  data-port byte address.
- REQ-012 wdata_b  in  16  data-port write data.
- REQ-013 resp_b  out  1  data-port transaction complete.
- REQ-014 rdata_b  out  16  data-port read data.
- REQ-015 pmem_read / pmem_write  out  1 each  physical-memory request strobes.
- REQ-016 pmem_wmask  out  2  physical-memory byte enables.
- REQ-017 pmem_address / pmem_wdata  out  16 each  physical-memory address and write data.
- REQ-018 pmem_resp  in  1  physical-memory completion.
- REQ-019 pmem_rdata  in  16  physical-memory read data, valid with pmem_resp.

Function
- REQ-020 FSM states SHALL be IDLE, SERVE_A, SERVE_B, encoded in registered state.
- REQ-021 IDLE: B pending (read_b|write_b) SHALL select SERVE_B; else read_a SHALL select SERVE_A; else stay in IDLE.
- REQ-022 On entry to SERVE_x, address, wdata, wmask and op of port x SHALL be latched; pmem_* SHALL be driven only from latched registers.
- REQ-023 In SERVE_x, pmem_read or pmem_write SHALL stay asserted per the latched op until pmem_resp; port A SHALL never assert pmem_write; pmem_wmask SHALL be 2'b11 for A reads.
- REQ-024 resp_x SHALL equal pmem_resp AND (state==SERVE_x), combinationally, same cycle.
- REQ-025 rdata_a and rdata_b SHALL both equal pmem_rdata combinationally.
- REQ-026 In the cycle after pmem_resp, state SHALL be IDLE; minimum latency is request in IDLE at cycle 0, pmem strobe at cycle 1, resp_x at cycle 1 if pmem_resp arrives at cycle 1.
- REQ-027 Requester input changes during SERVE_x SHALL be ignored until the return to IDLE.
- REQ-028 pmem_resp in IDLE SHALL be ignored; resp_a and resp_b SHALL stay 0.
- REQ-029 read_b and write_b both high SHALL be treated as write.
- REQ-030 wmask_b=2'b00 writes SHALL still be forwarded and completed.
- REQ-031 In IDLE, all pmem strobes SHALL be 0; pmem_address, pmem_wdata and pmem_wmask SHALL hold their last values.

Reset
- REQ-032 reset SHALL force IDLE immediately, asynchronously, mid-transaction included; pmem_read, pmem_write, resp_a and resp_b go to 0 in the same cycle.
- REQ-033 Reset values SHALL be: latched address, wdata 16'h0000; wmask 2'b00; round-robin pointer favours B.

Configuration
- REQ-034 Macro ARB_ROUND_ROBIN_EN SHALL control tie-breaking when A and B are both pending in IDLE.
- REQ-035 Undefined: fixed B-over-A priority per REQ-021. Defined: a 1-bit last-served pointer SHALL grant the port not served last. The pointer updates on each grant. Single-requester behaviour SHALL be unchanged.

Verification
- REQ-036 Reset, then read_a=1, address_a=16'h0040, memory returns 16'h1234 after 3 cycles -> pmem_read high 3 cycles, resp_a 1 cycle, rdata_a=16'h1234, resp_b=0.
- REQ-037 write_b=1, address_b=16'h0102, wdata_b=16'hBEEF, wmask_b=2'b01 -> pmem_write=1 with identical address/data/mask; resp_b on pmem_resp.
- REQ-038 read_a and read_b asserted in the same cycle, macro undefined -> B served first, then A; macro defined, four back-to-back conflicts -> grants B, A, B, A.
- REQ-039 During SERVE_A, change address_a from 16'h0010 to 16'h0020 -> pmem_address stays 16'h0010 until resp_a.
- REQ-040 Assert reset for one cycle while SERVE_B waits on pmem_resp -> pmem_write=0 immediately; a later pmem_resp produces no resp_b; state is IDLE.
